// File: rtl/disp_pkg.sv
// Shared constants, scan-state encoding and one-hot helper for the 4-digit display scan path.
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;
    localparam int WORD_W     = NUM_DIGITS * NIB_W;

    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = 4'b0000;
    localparam logic [NUM_DIGITS-1:0] SEL_DIG0 = 4'b0001;
    localparam logic [NUM_DIGITS-1:0] SEL_DIG1 = 4'b0010;
    localparam logic [NUM_DIGITS-1:0] SEL_DIG2 = 4'b0100;
    localparam logic [NUM_DIGITS-1:0] SEL_DIG3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
        logic [NUM_DIGITS-1:0] oh;
        case (idx)
            2'd0:    oh = SEL_DIG0;
            2'd1:    oh = SEL_DIG1;
            2'd2:    oh = SEL_DIG2;
            default: oh = SEL_DIG3;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Display-word update handshake: the sender offers a word, the scanner accepts it at a frame edge.
interface digit_scan_ctrl_if;
    import disp_pkg::*;

    logic              upd_valid;
    logic [WORD_W-1:0] upd_data;
    logic              upd_ready;

    modport master (output upd_valid, output upd_data, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_data, output upd_ready);

endinterface

// File: rtl/scan_tick_gen.sv
// Slot counter for the digit scan: counts 0..PRESCALE-1 while running and flags the compare points.
module scan_tick_gen #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic terminal,
    output logic blank_start,
    output logic pre_terminal
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] TERM_VAL  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] PRE_VAL   = CNT_W'(PRESCALE - 2);
    localparam logic [CNT_W-1:0] BLANK_VAL = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;

    assign terminal     = (count_reg == TERM_VAL);
    assign blank_start  = (count_reg == BLANK_VAL);
    assign pre_terminal = (count_reg == PRE_VAL);

    // Held at zero whenever the scan is not running, so a restart always begins a full slot.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count_reg <= '0;
        end else if (terminal) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + ONE;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan controller: one-hot digit strobe with end-of-slot blanking and frame-aligned word update.
// Define DIGIT_SCAN_LZB_EN to enable leading-zero blanking of digits 1..3.
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    digit_scan_ctrl_if.slave      upd,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [WORD_W-1:0]     N,
    output logic [1:0]            digit_idx,
    output logic                  frame_done
);

    scan_state_t           state_reg, state_next;
    logic [1:0]            digit_reg, digit_next;
    logic [NUM_DIGITS-1:0] sel_reg, sel_next;
    logic [WORD_W-1:0]     n_reg, n_next;
    logic                  ready_reg, ready_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  terminal, blank_start, pre_terminal;
    logic                  run, accept, digit_lit;

    assign run = en && (state_reg != IDLE);

    scan_tick_gen #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .terminal     (terminal),
        .blank_start  (blank_start),
        .pre_terminal (pre_terminal)
    );

    assign accept = upd.upd_valid && ready_reg;
    assign n_next = accept ? upd.upd_data : n_reg;

`ifdef DIGIT_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] upper_zero;
    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign nib_zero[gi]   = (n_next[gi*NIB_W +: NIB_W] == '0);
        assign upper_zero[gi] = &nib_zero[NUM_DIGITS-1:gi];
    end
    // Mask is taken from the word that will be on N alongside this strobe.
    assign digit_lit = (digit_next == 2'd0) || !upper_zero[digit_next];
`else
    assign digit_lit = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        if (!en) begin
            state_next = IDLE;
            digit_next = 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = SHOW;
                    digit_next = 2'd0;
                end
                SHOW: begin
                    // Terminal wins so that BLANK_CYCLES=0 goes straight to the next digit.
                    if (terminal) begin
                        digit_next = digit_reg + 2'd1;
                    end else if (blank_start) begin
                        state_next = BLANK;
                    end
                end
                BLANK: begin
                    if (terminal) begin
                        state_next = SHOW;
                        digit_next = digit_reg + 2'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    digit_next = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        sel_next        = SEL_OFF;
        frame_done_next = run && terminal && (digit_reg == 2'd3);
        // Ready one cycle ahead: the next cycle is the last one of slot 3.
        ready_next      = (state_next == IDLE) ||
                          (run && pre_terminal && !terminal && (digit_reg == 2'd3));
        if (state_next == SHOW && digit_lit) begin
            sel_next = digit_onehot(digit_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            digit_reg      <= 2'd0;
            sel_reg        <= SEL_OFF;
            n_reg          <= '0;
            ready_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            digit_reg      <= digit_next;
            sel_reg        <= sel_next;
            n_reg          <= n_next;
            ready_reg      <= ready_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign sel           = sel_reg;
    assign N             = n_reg;
    assign digit_idx     = digit_reg;
    assign frame_done    = frame_done_reg;
    assign upd.upd_ready = ready_reg;

endmodule
